// File: rtl/pulse_capture_sequencer.sv
// Run controller for pulse_integrator: flushes the integrator, arms its trigger,
// and gates its sum stream downstream until count, timeout, error or abort ends the run.
module pulse_capture_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SUM_WIDTH     = 16,
    parameter int COUNT_WIDTH   = 16,
    parameter int TIMEOUT_WIDTH = 32,
    parameter int FLUSH_CYCLES  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [WIDTH-1:0]         cfg_trigger_level,
    input  logic [1:0]               cfg_trigger_mode,
    input  logic [COUNT_WIDTH-1:0]   cfg_pulse_count,
    input  logic [TIMEOUT_WIDTH-1:0] cfg_timeout,
    output logic                     integ_resetn,
    output logic [WIDTH-1:0]         integ_trigger_level,
    output logic [1:0]               integ_trigger_enable,
    input  logic                     integ_adder_err,
    input  logic                     integ_overflow_err,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [SUM_WIDTH-1:0]     s_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [SUM_WIDTH-1:0]     m_tdata,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               status,
    output logic [COUNT_WIDTH-1:0]   pulses_captured,
    output logic [1:0]               dbg_state
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, RUN = 2'd2, STOP = 2'd3} state_t;

    state_t                   state, state_nxt;
    logic [WIDTH-1:0]         lat_level;
    logic [1:0]               lat_mode;
    logic [COUNT_WIDTH-1:0]   lat_count;
    logic [TIMEOUT_WIDTH-1:0] lat_timeout;
    logic [FLUSH_W-1:0]       flush_cnt;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

    logic                     start_ok;
    logic                     in_run;
    logic                     fire;
    logic [COUNT_WIDTH-1:0]   cnt_inc;
    logic                     count_hit;
    logic                     timed_out;
    logic                     run_exit;

    // A beat transfers only when valid and ready are both high in the same cycle;
    // valid never waits on ready. Outside RUN the integrator's beats are drained and dropped.
    assign in_run    = (state == RUN);
    assign start_ok  = (state == IDLE) && start && !done;
    assign fire      = in_run && s_tvalid && m_tready;
    assign cnt_inc   = (&pulses_captured) ? pulses_captured
                                          : pulses_captured + COUNT_WIDTH'(1);
    assign count_hit = fire && (lat_count != '0) && (cnt_inc == lat_count);
    assign timed_out = in_run && (lat_timeout != '0) && (tmo_cnt == TIMEOUT_WIDTH'(1));
    assign run_exit  = abort || integ_adder_err || integ_overflow_err || timed_out || count_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_ok) state_nxt = FLUSH;
            FLUSH: begin
                if (abort)                              state_nxt = STOP;
                else if (flush_cnt == FLUSH_W'(1))      state_nxt = RUN;
            end
            RUN:   if (run_exit) state_nxt = STOP;
            STOP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        integ_resetn         = (state == RUN) || (state == STOP);
        integ_trigger_enable = in_run ? lat_mode : 2'd0;
        integ_trigger_level  = lat_level;
        busy                 = (state != IDLE);
        m_tvalid             = in_run && s_tvalid;
        s_tready             = in_run ? m_tready : 1'b1;
        m_tdata              = s_tdata;
        dbg_state            = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_level       <= '0;
            lat_mode        <= '0;
            lat_count       <= '0;
            lat_timeout     <= '0;
            flush_cnt       <= '0;
            tmo_cnt         <= '0;
            status          <= '0;
            pulses_captured <= '0;
            done            <= 1'b0;
        end else begin
            done <= (state == STOP);
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        lat_level       <= cfg_trigger_level;
                        lat_mode        <= cfg_trigger_mode;
                        lat_count       <= cfg_pulse_count;
                        lat_timeout     <= cfg_timeout;
                        status          <= '0;
                        pulses_captured <= '0;
                        flush_cnt       <= FLUSH_W'(FLUSH_CYCLES);
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - FLUSH_W'(1);
                    if (flush_cnt == FLUSH_W'(1)) tmo_cnt <= lat_timeout;
                    if (abort) status[3] <= 1'b1;
                end
                RUN: begin
                    if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - TIMEOUT_WIDTH'(1);
                    if (fire) pulses_captured <= cnt_inc;
                    // Every exit cause present in the final RUN cycle is recorded together.
                    status <= status | {abort, integ_adder_err, integ_overflow_err, timed_out};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_capture_sequencer.sv
// Directed bench for pulse_capture_sequencer: a table of run scenarios checked
// cycle by cycle against hand-computed run windows, plus reset and idle sequences.
module tb_pulse_capture_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [7:0]  cfg_trigger_level;
    logic [1:0]  cfg_trigger_mode;
    logic [15:0] cfg_pulse_count;
    logic [31:0] cfg_timeout;
    logic        integ_resetn;
    logic [7:0]  integ_trigger_level;
    logic [1:0]  integ_trigger_enable;
    logic        integ_adder_err, integ_overflow_err;
    logic        s_tvalid, s_tready, m_tvalid, m_tready;
    logic [15:0] s_tdata, m_tdata;
    logic        busy, done;
    logic [3:0]  status;
    logic [15:0] pulses_captured;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    pulse_capture_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_trigger_level(cfg_trigger_level), .cfg_trigger_mode(cfg_trigger_mode),
        .cfg_pulse_count(cfg_pulse_count), .cfg_timeout(cfg_timeout),
        .integ_resetn(integ_resetn), .integ_trigger_level(integ_trigger_level),
        .integ_trigger_enable(integ_trigger_enable),
        .integ_adder_err(integ_adder_err), .integ_overflow_err(integ_overflow_err),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .busy(busy), .done(done), .status(status),
        .pulses_captured(pulses_captured), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  level;
        logic [1:0]  mode;
        logic [15:0] count;
        logic [31:0] timeout;
        int          period;     // s_tvalid pulses at k % period == 0, k > 0
        logic        ready;
        int          ovf_k;      // cycle of integ_overflow_err pulse, -1 none
        int          add_k;      // cycle of integ_adder_err pulse
        int          abort_k;    // cycle of abort pulse
        int          poke_k;     // cycle of a start with altered cfg while busy
        logic        sad;        // also pulse start in the done cycle
        int          stop_k;     // expected STOP cycle (start driven at k=0)
        logic [3:0]  st;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0;
        integ_adder_err = 1'b0; integ_overflow_err = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    endtask

    // driver + cycle model for one table scenario
    task automatic run_vec(input vec_t v);
        logic [15:0] exp_cnt;
        logic        run_k, exp_rstn;
        exp_cnt = '0;
        for (int k = 0; k <= v.stop_k + 2; k++) begin
            @(posedge clk); #1;
            start = (k == 0) || (k == v.poke_k) || (v.sad && k == v.stop_k + 1);
            if (k == 0) begin
                cfg_trigger_level = v.level;
                cfg_trigger_mode  = v.mode;
                cfg_pulse_count   = v.count;
                cfg_timeout       = v.timeout;
            end else if (start) begin
                cfg_trigger_level = ~v.level;
                cfg_trigger_mode  = v.mode ^ 2'b11;
                cfg_pulse_count   = 16'd7;
                cfg_timeout       = 32'd9;
            end
            abort              = (k == v.abort_k);
            integ_overflow_err = (k == v.ovf_k);
            integ_adder_err    = (k == v.add_k);
            s_tvalid           = (k > 0) && (k % v.period == 0);
            s_tdata            = 16'($urandom);
            m_tready           = v.ready;
            #2;
            run_k    = (k >= 5) && (k < v.stop_k);
            exp_rstn = run_k || (k == v.stop_k);
            chk("m_tvalid", m_tvalid, run_k && s_tvalid);
            chk("s_tready", s_tready, run_k ? v.ready : 1'b1);
            if (m_tvalid) chk("m_tdata", m_tdata, s_tdata);
            chk("integ_resetn", integ_resetn, exp_rstn);
            chk("trig_enable", integ_trigger_enable, run_k ? v.mode : 2'd0);
            chk("busy", busy, (k >= 1) && (k <= v.stop_k));
            chk("done", done, k == v.stop_k + 1);
            if (k >= 1) begin
                chk("trig_level", integ_trigger_level, v.level);
                chk("pulses_run", pulses_captured, exp_cnt);
            end
            if (run_k && s_tvalid && v.ready) exp_cnt++;
        end
        chk("status_end", status, v.st);
        chk("pulses_end", pulses_captured, v.pc);
        idle_inputs();
    endtask

    initial begin
        //          level   mode  count  tmo    per rdy ovf add abt poke sad stop st     pc
        tbl[0] = '{8'd150, 2'd1, 16'd3, 32'd0,   20, 1, -1, -1, -1, 10,  1,  61, 4'b0000, 16'd3};
        tbl[1] = '{8'h10,  2'd2, 16'd0, 32'd100, 30, 1, -1, -1, -1, 2,   0, 105, 4'b0001, 16'd3};
        tbl[2] = '{8'h7f,  2'd3, 16'd0, 32'd0,   20, 1, 25, -1, -1, -1,  0,  26, 4'b0010, 16'd1};
        tbl[3] = '{8'h80,  2'd1, 16'd0, 32'd0,   20, 1, -1, 25, -1, -1,  0,  26, 4'b0100, 16'd1};
        tbl[4] = '{8'h22,  2'd1, 16'd2, 32'd0,   20, 1, -1, -1, 40, -1,  0,  41, 4'b1000, 16'd2};
        tbl[5] = '{8'h33,  2'd2, 16'd0, 32'd0,   20, 1, -1, -1, 2,  -1,  0,   3, 4'b1000, 16'd0};
        tbl[6] = '{8'h44,  2'd1, 16'd0, 32'd10,  20, 1,  3, 14, -1, -1,  0,  15, 4'b0101, 16'd0};
        tbl[7] = '{8'h55,  2'd1, 16'd1, 32'd30,  10, 0, -1, -1, -1, -1,  0,  35, 4'b0001, 16'd0};
        tbl[8] = '{8'h66,  2'd3, 16'd1, 32'd1,    5, 1,  6, -1, 6,  -1,  0,   6, 4'b0001, 16'd1};

        idle_inputs();
        cfg_trigger_level = '0; cfg_trigger_mode = '0; cfg_pulse_count = '0; cfg_timeout = '0;
        reset = 1'b1;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_status", status, 4'd0);
        chk("rst_pulses", pulses_captured, 16'd0);
        chk("rst_resetn", integ_resetn, 1'b0);
        chk("rst_enable", integ_trigger_enable, 2'd0);
        chk("rst_level", integ_trigger_level, 8'd0);
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

        // idle gating: beats dropped, counter untouched
        @(posedge clk); #1;
        s_tvalid = 1'b1; m_tready = 1'b0; s_tdata = 16'hbeef;
        #2;
        chk("idle_s_tready", s_tready, 1'b1);
        chk("idle_m_tvalid", m_tvalid, 1'b0);
        @(posedge clk); #3;
        chk("idle_pulses", pulses_captured, 16'd1);
        chk("idle_busy", busy, 1'b0);
        idle_inputs();

        // asynchronous reset in the middle of a run
        for (int k = 0; k <= 30; k++) begin
            @(posedge clk); #1;
            start             = (k == 0);
            cfg_trigger_level = 8'd150;
            cfg_trigger_mode  = 2'd1;
            cfg_pulse_count   = 16'd3;
            cfg_timeout       = 32'd0;
            s_tvalid          = (k == 20) || (k == 30);
        end
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_resetn", integ_resetn, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_enable", integ_trigger_enable, 2'd0);
        chk("mid_rst_level", integ_trigger_level, 8'd0);
        chk("mid_rst_m_tvalid", m_tvalid, 1'b0);
        chk("mid_rst_pulses", pulses_captured, 16'd0);
        chk("mid_rst_status", status, 4'd0);
        chk("mid_rst_done", done, 1'b0);
        idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #3;
            chk("post_rst_done", done, 1'b0);
            chk("post_rst_busy", busy, 1'b0);
        end

        run_vec(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
